// File: rtl/alu32_pkg.sv
// Shared types and default widths for the ALU operand loader.
// Beat count is derived from the operand and beat widths.
package alu32_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IN_W   = 8;
    localparam int BEATS      = DEF_DATA_W / DEF_IN_W;
    localparam int OPCNT_W    = 16;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } loadState_e;

endpackage

// File: rtl/alu32_operand_loader_if.sv
// Byte-stream input and operand-set output handshakes of the loader.
// master drives beats and accepts sets; slave is the loader itself.
interface alu32_operand_loader_if
    import alu32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_W   = DEF_IN_W
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_sub;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub_add;

    modport master (
        output in_valid, in_data, in_sub, op_ready,
        input  in_ready, op_valid, a, b, sub_add
    );

    modport slave (
        input  in_valid, in_data, in_sub, op_ready,
        output in_ready, op_valid, a, b, sub_add
    );
endinterface

// File: rtl/alu32_byte_shift_reg.sv
// Right-shift operand register: each enabled beat enters at the top,
// so after DATA_W/IN_W beats the first beat sits in the low bits.
module alu32_byte_shift_reg #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [IN_W-1:0]   din,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[DATA_W-1:IN_W]};
        end
    end
endmodule

// File: rtl/alu32_operand_loader.sv
// Assembles two operands and add/sub select from a byte stream.
// Optional consume counter: define ALU32_LOADER_OPCNT_EN.
module alu32_operand_loader
    import alu32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_W   = DEF_IN_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    alu32_operand_loader_if.slave bus
`ifdef ALU32_LOADER_OPCNT_EN
    ,
    output logic [OPCNT_W-1:0] op_count
`endif
);
    localparam int NBEATS = DATA_W / IN_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    loadState_e       state;
    logic [CNT_W-1:0] beatCnt;
    logic             inReadyR;
    logic             opValidR;
    logic             subAddR;
    logic             accept;
    logic             consume;
    logic             shiftA;
    logic             shiftB;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;

    assign accept  = bus.in_valid & inReadyR;
    assign consume = bus.op_valid & bus.op_ready;
    // clear wins over any beat landing in the same cycle
    assign shiftA  = accept & ~clear & (state == LOAD_A);
    assign shiftB  = accept & ~clear & (state == LOAD_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            beatCnt  <= '0;
            inReadyR <= 1'b0;
            opValidR <= 1'b0;
        end else if (clear) begin
            state    <= LOAD_A;
            beatCnt  <= '0;
            inReadyR <= 1'b1;
            opValidR <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    inReadyR <= 1'b1;
                    if (accept) begin
                        if (beatCnt == LAST) begin
                            beatCnt <= '0;
                            state   <= LOAD_B;
                        end else begin
                            beatCnt <= beatCnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (beatCnt == LAST) begin
                            beatCnt  <= '0;
                            state    <= ISSUE;
                            inReadyR <= 1'b0;
                            opValidR <= 1'b1;
                        end else begin
                            beatCnt <= beatCnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (consume) begin
                        state    <= LOAD_A;
                        inReadyR <= 1'b1;
                        opValidR <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD_A;
                    beatCnt  <= '0;
                    inReadyR <= 1'b1;
                    opValidR <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            subAddR <= 1'b0;
        end else if (shiftA && beatCnt == '0) begin
            subAddR <= bus.in_sub;
        end
    end

    alu32_byte_shift_reg #(.DATA_W(DATA_W), .IN_W(IN_W)) uShiftA (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shiftA),
        .din   (bus.in_data),
        .q     (aReg)
    );

    alu32_byte_shift_reg #(.DATA_W(DATA_W), .IN_W(IN_W)) uShiftB (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shiftB),
        .din   (bus.in_data),
        .q     (bReg)
    );

`ifdef ALU32_LOADER_OPCNT_EN
    logic [OPCNT_W-1:0] opCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCnt <= '0;
        end else if (consume && !clear) begin
            opCnt <= opCnt + OPCNT_W'(1);
        end
    end

    assign op_count = opCnt;
`endif

    assign bus.in_ready = inReadyR;
    assign bus.op_valid = opValidR;
    assign bus.a        = aReg;
    assign bus.b        = bReg;
    assign bus.sub_add  = subAddR;
endmodule

// File: tb/tb_alu32_operand_loader.sv
// Directed bench for alu32_operand_loader with hand-computed operands.
// Optional counter checks build when ALU32_LOADER_OPCNT_EN is defined.
module tb_alu32_operand_loader;

    logic clk;
    logic rst_n;
    logic clear;
    int   errors;
    int   checks;

`ifdef ALU32_LOADER_OPCNT_EN
    logic [15:0] opCount;
`endif

    alu32_operand_loader_if #(.DATA_W(32), .IN_W(8)) bus ();

    alu32_operand_loader #(.DATA_W(32), .IN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
`ifdef ALU32_LOADER_OPCNT_EN
        ,
        .op_count (opCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Streams A then B, LSB first; in_sub is inverted after beat 0 to
    // show only the first A beat is sampled. Ends on the issue negedge.
    task automatic feed(input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input bit gaps);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? av : bv;
            check("inReadyLoad", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = w[8*(i%4) +: 8];
            bus.in_sub   = (i == 0) ? s : ~s;
            @(negedge clk);
            if (i == 6) check("noEarlyValid", {31'd0, bus.op_valid}, 32'd0);
            if (gaps && i < 7) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hFF;
                @(negedge clk);
                if (i == 6) check("noValidGap", {31'd0, bus.op_valid}, 32'd0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic checkSet(input string tag, input logic [31:0] av,
                            input logic [31:0] bv, input logic s);
        check({tag, "_valid"}, {31'd0, bus.op_valid}, 32'd1);
        check({tag, "_inReady"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_a"}, bus.a, av);
        check({tag, "_b"}, bus.b, bv);
        check({tag, "_sub"}, {31'd0, bus.sub_add}, {31'd0, s});
    endtask

    logic [31:0] aluRes;

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sub   = 1'b0;
        bus.op_ready = 1'b1;

        #12;
        check("rstValid", {31'd0, bus.op_valid}, 32'd0);
        check("rstReady", {31'd0, bus.in_ready}, 32'd0);
        check("rstA", bus.a, 32'd0);
        check("rstB", bus.b, 32'd0);
        check("rstSub", {31'd0, bus.sub_add}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("readyAfterRst", {31'd0, bus.in_ready}, 32'd1);

        // Streaming add
        feed(32'h12345678, 32'h00000001, 1'b0, 1'b0);
        checkSet("add", 32'h12345678, 32'h00000001, 1'b0);
        @(negedge clk);
        check("addDrop", {31'd0, bus.op_valid}, 32'd0);
        check("addReady", {31'd0, bus.in_ready}, 32'd1);

        // Sub with backpressure; stray beats offered while stalled
        bus.op_ready = 1'b0;
        feed(32'h0000000F, 32'h00000001, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            checkSet("stall", 32'h0000000F, 32'h00000001, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b1;
        aluRes = bus.sub_add ? bus.a - bus.b : bus.a + bus.b;
        check("aluResult", aluRes, 32'h0000000E);
        @(negedge clk);
        check("subDrop", {31'd0, bus.op_valid}, 32'd0);

        // Input gaps
        feed(32'h12345678, 32'h00000001, 1'b0, 1'b1);
        checkSet("gaps", 32'h12345678, 32'h00000001, 1'b0);
        @(negedge clk);
        check("gapsDrop", {31'd0, bus.op_valid}, 32'd0);

        // clear after two B beats, with a beat offered in the clear cycle
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h11 * 8'(i + 1);
            bus.in_sub   = 1'b1;
            @(negedge clk);
        end
        bus.in_data = 8'h77;
        clear       = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clrValid", {31'd0, bus.op_valid}, 32'd0);
        check("clrReady", {31'd0, bus.in_ready}, 32'd1);
        feed(32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
        checkSet("fresh", 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        check("freshDrop", {31'd0, bus.op_valid}, 32'd0);

        // Async reset while issuing
        bus.op_ready = 1'b0;
        feed(32'h01020304, 32'h0A0B0C0D, 1'b1, 1'b0);
        checkSet("preRst", 32'h01020304, 32'h0A0B0C0D, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arstValid", {31'd0, bus.op_valid}, 32'd0);
        check("arstA", bus.a, 32'd0);
        check("arstB", bus.b, 32'd0);
        check("arstSub", {31'd0, bus.sub_add}, 32'd0);
        check("arstReady", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.op_ready = 1'b1;
        @(negedge clk);
        check("arstReadyUp", {31'd0, bus.in_ready}, 32'd1);

`ifdef ALU32_LOADER_OPCNT_EN
        check("cntRst", {16'd0, opCount}, 32'd0);
        feed(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        @(negedge clk);
        check("cntOne", {16'd0, opCount}, 32'd1);
        bus.op_ready = 1'b0;
        feed(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        bus.op_ready = 1'b1;
        clear        = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("cntClr", {16'd0, opCount}, 32'd1);
        check("cntClrValid", {31'd0, bus.op_valid}, 32'd0);
        force dut.opCnt = 16'hFFFE;
        #1;
        release dut.opCnt;
        check("cntPreload", {16'd0, opCount}, 32'h0000FFFE);
        feed(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        @(negedge clk);
        check("cntFFFF", {16'd0, opCount}, 32'h0000FFFF);
        feed(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        @(negedge clk);
        check("cntWrap", {16'd0, opCount}, 32'h00000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
